// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - FSM state type, default sizes/timing and timer width helper for the SRAM access controller
package sram_ctrl_pkg;

  localparam int DEF_ROW_ADDR_WIDTH = 4;
  localparam int DEF_COL_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_PRE_CYCLES     = 1;
  localparam int DEF_ACC_CYCLES     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_SENSE     = 3'd3,
    ST_DONE      = 3'd4
  } sram_state_e;

  // Counter width big enough for the longer of the two timed phases.
  function automatic int timer_width(input int pre_cycles, input int acc_cycles);
    int longest;
    longest = (pre_cycles > acc_cycles) ? pre_cycles : acc_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter that flags the last cycle of a timed array phase
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int CNT_W = timer_width(DEF_PRE_CYCLES, DEF_ACC_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load phase length minus one on phase entry, then count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - single-request SRAM array sequencer (precharge/access/sense); optional SRAM_CTRL_PARITY_EN
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROW_ADDR_WIDTH = DEF_ROW_ADDR_WIDTH,
  parameter int COL_ADDR_WIDTH = DEF_COL_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PRE_CYCLES     = DEF_PRE_CYCLES,
  parameter int ACC_CYCLES     = DEF_ACC_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_we,
  input  logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                  req_wdata,
  output logic [ROW_ADDR_WIDTH-1:0]              row_addr,
  output logic [COL_ADDR_WIDTH-1:0]              col_addr,
  output logic                                   row_en,
  output logic                                   col_en,
  output logic                                   precharge_en,
  output logic                                   write_en,
  output logic                                   sense_en,
`ifdef SRAM_CTRL_PARITY_EN
  output logic [DATA_WIDTH:0]                    bl_wdata,
  input  logic [DATA_WIDTH:0]                    bl_rdata,
`else
  output logic [DATA_WIDTH-1:0]                  bl_wdata,
  input  logic [DATA_WIDTH-1:0]                  bl_rdata,
`endif
  output logic                                   rsp_valid,
`ifdef SRAM_CTRL_PARITY_EN
  output logic                                   rsp_perr,
`endif
  output logic [DATA_WIDTH-1:0]                  rsp_rdata
);

  localparam int ADDR_W = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  localparam int CNT_W  = timer_width(PRE_CYCLES, ACC_CYCLES);
`ifdef SRAM_CTRL_PARITY_EN
  localparam int BL_W   = DATA_WIDTH + 1;
`else
  localparam int BL_W   = DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYCLES - 1);

  sram_state_e               r_state;
  sram_state_e               w_next_state;
  logic                      r_we;
  logic [ROW_ADDR_WIDTH-1:0] r_row_addr;
  logic [COL_ADDR_WIDTH-1:0] r_col_addr;
  logic [BL_W-1:0]           r_bl_wdata;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                      w_accept;
  logic                      w_load;
  logic [CNT_W-1:0]          w_load_val;
  logic                      w_phase_done;
`ifdef SRAM_CTRL_PARITY_EN
  logic                      r_perr;
`endif

  assign w_accept = req_valid & req_ready;

  sram_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_phase_done)
  );

  // State register; reset aborts whatever access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and phase timer loading on entry to each timed phase.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_PRECHARGE;
          w_load       = 1'b1;
          w_load_val   = PRE_LOAD;
        end
      end
      ST_PRECHARGE: begin
        if (w_phase_done) begin
          w_next_state = ST_ACCESS;
          w_load       = 1'b1;
          w_load_val   = ACC_LOAD;
        end
      end
      ST_ACCESS: begin
        if (w_phase_done) begin
          w_next_state = r_we ? ST_DONE : ST_SENSE;
        end
      end
      ST_SENSE: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request latch at accept and sense-amp capture at the end of the SENSE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_row_addr  <= '0;
      r_col_addr  <= '0;
      r_bl_wdata  <= '0;
      r_rsp_rdata <= '0;
`ifdef SRAM_CTRL_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_we       <= req_we;
        r_row_addr <= req_addr[ADDR_W-1:COL_ADDR_WIDTH];
        r_col_addr <= req_addr[COL_ADDR_WIDTH-1:0];
`ifdef SRAM_CTRL_PARITY_EN
        r_bl_wdata <= {^req_wdata, req_wdata};
        r_perr     <= 1'b0;
`else
        r_bl_wdata <= req_wdata;
`endif
      end
      if (r_state == ST_SENSE) begin
        r_rsp_rdata <= bl_rdata[DATA_WIDTH-1:0];
`ifdef SRAM_CTRL_PARITY_EN
        r_perr      <= bl_rdata[DATA_WIDTH] ^ (^bl_rdata[DATA_WIDTH-1:0]);
`endif
      end
    end
  end

  // Strobes are pure functions of the phase, so precharge and row/col can never overlap.
  assign req_ready    = (r_state == ST_IDLE);
  assign precharge_en = (r_state == ST_PRECHARGE);
  assign row_en       = (r_state == ST_ACCESS);
  assign col_en       = (r_state == ST_ACCESS);
  assign write_en     = (r_state == ST_ACCESS) & r_we;
  assign sense_en     = (r_state == ST_SENSE);
  assign rsp_valid    = (r_state == ST_DONE);
  assign row_addr     = r_row_addr;
  assign col_addr     = r_col_addr;
  assign bl_wdata     = r_bl_wdata;
  assign rsp_rdata    = r_rsp_rdata;
`ifdef SRAM_CTRL_PARITY_EN
  assign rsp_perr     = r_perr & (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - randomized self-checking bench for sram_access_ctrl, SRAM_CTRL_PARITY_EN aware
`timescale 1ns/1ps
module tb_sram_access_ctrl;

  localparam int RW = 4;
  localparam int CW = 4;
  localparam int DW = 8;
  localparam int AW = RW + CW;
`ifdef SRAM_CTRL_PARITY_EN
  localparam int BW = DW + 1;
`else
  localparam int BW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid [2];
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] bl_rdata;

  logic          req_ready    [2];
  logic [RW-1:0] row_addr     [2];
  logic [CW-1:0] col_addr     [2];
  logic          row_en       [2];
  logic          col_en       [2];
  logic          precharge_en [2];
  logic          write_en     [2];
  logic          sense_en     [2];
  logic [BW-1:0] bl_wdata     [2];
  logic          rsp_valid    [2];
  logic [DW-1:0] rsp_rdata    [2];
  logic          rsp_perr     [2];

  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_rd [2];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: default timing. Instance 1: PRE_CYCLES=3, ACC_CYCLES=1.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_access_ctrl #(
      .ROW_ADDR_WIDTH (RW),
      .COL_ADDR_WIDTH (CW),
      .DATA_WIDTH     (DW),
      .PRE_CYCLES     (g ? 3 : 1),
      .ACC_CYCLES     (g ? 1 : 2)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .row_addr     (row_addr[g]),
      .col_addr     (col_addr[g]),
      .row_en       (row_en[g]),
      .col_en       (col_en[g]),
      .precharge_en (precharge_en[g]),
      .write_en     (write_en[g]),
      .sense_en     (sense_en[g]),
      .bl_wdata     (bl_wdata[g]),
      .bl_rdata     (bl_rdata),
      .rsp_valid    (rsp_valid[g]),
`ifdef SRAM_CTRL_PARITY_EN
      .rsp_perr     (rsp_perr[g]),
`endif
      .rsp_rdata    (rsp_rdata[g])
    );
`ifndef SRAM_CTRL_PARITY_EN
    assign rsp_perr[g] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] bl_word(input logic [DW-1:0] d, input logic bad_par);
`ifdef SRAM_CTRL_PARITY_EN
    return {(^d) ^ bad_par, d};
`else
    return d;
`endif
  endfunction

  task automatic check_idle_reset(input int s);
    check("rst_ready", req_ready[s], 1);
    check("rst_strobes", {precharge_en[s], row_en[s], col_en[s], write_en[s], sense_en[s], rsp_valid[s]}, 0);
    check("rst_addr", {row_addr[s], col_addr[s]}, 0);
    check("rst_bl_wdata", bl_wdata[s], 0);
    check("rst_rsp_rdata", rsp_rdata[s], 0);
    check("rst_perr", rsp_perr[s], 0);
  endtask

  // One request through the selected instance, checked against phase-length arithmetic and the memory array model.
  task automatic run_txn(input int s, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic bad_par);
    int pre, acc, lat, c, n_pre, n_acc, n_we, n_sense, done_cyc;
    logic stable_ok, excl_ok, busy_ok, obs_perr;
    logic [DW-1:0] rd, obs_rd;
    pre = s ? 3 : 1;
    acc = s ? 1 : 2;
    lat = pre + acc + (we ? 1 : 2);
    c = 0;
    while (req_ready[s] !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    check("ready_before_req", req_ready[s], 1);
    rd = mem[addr];
    req_valid[s] = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    n_pre = 0; n_acc = 0; n_we = 0; n_sense = 0; done_cyc = -1;
    stable_ok = 1'b1; excl_ok = 1'b1; busy_ok = 1'b1;
    obs_rd = '0; obs_perr = 1'b0;
    for (int k = 1; k <= lat + 2 && done_cyc < 0; k++) begin
      tick();
      req_valid[s] = (k < lat) ? 1'($urandom) : 1'b0;
      req_we = 1'($urandom);
      req_addr = AW'($urandom);
      req_wdata = DW'($urandom);
      if (row_addr[s] !== addr[AW-1:CW] || col_addr[s] !== addr[CW-1:0] || bl_wdata[s] !== bl_word(wd, 1'b0))
        stable_ok = 1'b0;
      if (precharge_en[s] && (row_en[s] || col_en[s])) excl_ok = 1'b0;
      if (row_en[s] !== col_en[s]) excl_ok = 1'b0;
      if (req_ready[s] !== 1'b0) busy_ok = 1'b0;
      if (precharge_en[s]) n_pre++;
      if (row_en[s]) n_acc++;
      if (write_en[s]) n_we++;
      if (sense_en[s]) n_sense++;
      if (sense_en[s]) bl_rdata = bl_word(rd, bad_par);
      else bl_rdata = BW'($urandom);
      if (rsp_valid[s]) begin
        done_cyc = k;
        obs_rd = rsp_rdata[s];
        obs_perr = rsp_perr[s];
      end
    end
    if (we) mem[addr] = wd;
    else exp_rd[s] = rd;
    check("latency", done_cyc, lat);
    check("precharge_cycles", n_pre, pre);
    check("access_cycles", n_acc, acc);
    check("write_en_cycles", n_we, we ? acc : 0);
    check("sense_cycles", n_sense, we ? 0 : 1);
    check("addr_data_stable", stable_ok, 1);
    check("strobe_exclusive", excl_ok, 1);
    check("ready_low_busy", busy_ok, 1);
    check("rsp_rdata", obs_rd, exp_rd[s]);
`ifdef SRAM_CTRL_PARITY_EN
    check("rsp_perr", obs_perr, bad_par & ~we);
`endif
    tick();
    check("rsp_valid_pulse", rsp_valid[s], 0);
    check("ready_after_done", req_ready[s], 1);
  endtask

  // req_valid held high: accepts must be one full round trip apart.
  task automatic run_stream(input int s, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int n);
    int per, acc_cnt, last, c;
    logic gap_ok, drained;
    per = (s ? 3 : 1) + (s ? 1 : 2) + (we ? 2 : 3);
    req_valid[s] = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    bl_rdata = bl_word(wd, 1'b0);
    acc_cnt = 0; last = -1; gap_ok = 1'b1;
    for (int k = 0; k < (n + 1) * per && acc_cnt < n; k++) begin
      if (req_ready[s]) begin
        if (last >= 0 && k - last != per) gap_ok = 1'b0;
        last = k;
        acc_cnt++;
      end
      tick();
    end
    req_valid[s] = 1'b0;
    drained = 1'b0;
    c = 0;
    while (!drained && c < 12) begin
      if (rsp_valid[s]) drained = 1'b1;
      tick();
      c++;
    end
    if (we) mem[addr] = wd;
    else exp_rd[s] = wd;
    check("stream_accepts", acc_cnt, n);
    check("stream_spacing", gap_ok, 1);
    check("stream_drained", drained, 1);
    check("stream_rsp_rdata", rsp_rdata[s], exp_rd[s]);
  endtask

  initial begin
    int c, n_rv;
    logic ready_ok;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    rst = 1'b1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    bl_rdata = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_reset(0);
    check_idle_reset(1);

    // Directed write then read of 0x3A / 0x5C on default timing.
    run_txn(0, 1'b1, 8'h3A, 8'h5C, 1'b0);
    run_txn(0, 1'b0, 8'h3A, 8'h00, 1'b0);
    check("read_3a_data", rsp_rdata[0], 8'h5C);

    for (int i = 0; i < 24; i++)
      run_txn(0, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0);

    run_stream(0, 1'b1, 8'hC4, 8'h9E, 3);
    run_stream(0, 1'b0, 8'h17, 8'h63, 3);

    // Reset pulsed while the array is in its access phase.
    req_valid[0] = 1'b1;
    req_we = 1'b0;
    req_addr = AW'($urandom);
    req_wdata = DW'($urandom);
    tick();
    req_valid[0] = 1'b0;
    c = 0;
    while (row_en[0] !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    check("rst_reached_access", row_en[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check_idle_reset(0);
    n_rv = 0;
    ready_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid[0]) n_rv++;
      if (req_ready[0] !== 1'b1) ready_ok = 1'b0;
    end
    check("rst_no_rsp", n_rv, 0);
    check("rst_ready_held", ready_ok, 1);

    // Long precharge / short access instance.
    run_txn(1, 1'b1, 8'h3A, 8'hA5, 1'b0);
    run_txn(1, 1'b0, 8'h3A, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++)
      run_txn(1, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0);

`ifdef SRAM_CTRL_PARITY_EN
    mem[8'h11] = 8'h01;
    run_txn(0, 1'b0, 8'h11, 8'h00, 1'b1);
    run_txn(0, 1'b0, 8'h11, 8'h00, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed run still active expected finish");
    $fatal(1, "timeout");
  end

endmodule
